// File: rtl/pma_region_scanner.sv
// pma_region_scanner
//
// Sequential physical-memory-attribute classifier. The block accepts one
// physical address per request handshake. It then walks the non-idempotent,
// execute and cacheable rule tables of the core configuration, one rule index
// per cycle, with three range comparators shared across all rules. The result
// is returned as three sticky attribute flags over a valid/ready response.
//
// Ports:
//   clk_i           core clock
//   rst_i           asynchronous active-high reset
//   req_valid_i     address request valid
//   req_ready_o     scanner can accept a request (IDLE)
//   req_addr_i      64-bit physical address, sampled only on the accepting edge
//   kill_i          abort any in-flight scan; no response is produced
//   resp_valid_o    result valid (RESP)
//   resp_ready_i    consumer accepts the result
//   resp_nonidem_o  address lies in a non-idempotent region
//   resp_exec_o     address lies in an execute region
//   resp_cached_o   address lies in a cacheable region
//
// Optional feature: define CVA6_PMA_LASTHIT_EN to add a one-entry memo of the
// last completed response. A request for the memoised address skips the scan
// and is answered one cycle after it is accepted.

package config_pkg;
  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    int unsigned                 NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0] NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0] NonIdempotentLength;
    int unsigned                 NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0] ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0] ExecuteRegionLength;
    int unsigned                 NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0] CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0] CachedRegionLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module pma_region_scanner #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  input  logic        kill_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_nonidem_o,
  output logic        resp_exec_o,
  output logic        resp_cached_o
);

  localparam int unsigned KW   = $clog2(config_pkg::NrMaxRules) + 1;
  localparam int unsigned N_NI = CVA6Cfg.NrNonIdempotentRules;
  localparam int unsigned N_EX = CVA6Cfg.NrExecuteRegionRules;
  localparam int unsigned N_CA = CVA6Cfg.NrCachedRegionRules;
  localparam int unsigned N_01 = (N_NI > N_EX) ? N_NI : N_EX;
  localparam int unsigned N    = (N_01 > N_CA) ? N_01 : N_CA;

  localparam logic [KW-1:0] N_NI_K     = KW'(N_NI);
  localparam logic [KW-1:0] N_EX_K     = KW'(N_EX);
  localparam logic [KW-1:0] N_CA_K     = KW'(N_CA);
  localparam logic [KW-1:0] LAST_K     = (N == 0) ? '0 : KW'(N - 1);
  localparam logic          SKIP_SCAN  = (N == 0);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  state_e        state_q, state_d;
  logic [63:0]   addr_q;
  logic [KW-1:0] k_q;
  logic [2:0]    flags_q;     // {nonidem, exec, cached}
  logic [KW-2:0] idx;
  logic [2:0]    rule_hit;
  logic          memo_hit;
  logic [2:0]    memo_flags;
  logic          resp_done;

  // 65-bit limit so that base + len cannot wrap; len == 0 gives an empty range.
  function automatic logic range_hit(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] len);
    logic [64:0] limit;
    limit = {1'b0, base} + {1'b0, len};
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

  assign idx = k_q[KW-2:0];

  // A table shorter than N simply stops contributing once k passes its count.
  assign rule_hit[2] = (k_q < N_NI_K) &&
      range_hit(addr_q, CVA6Cfg.NonIdempotentAddrBase[idx], CVA6Cfg.NonIdempotentLength[idx]);
  assign rule_hit[1] = (k_q < N_EX_K) &&
      range_hit(addr_q, CVA6Cfg.ExecuteRegionAddrBase[idx], CVA6Cfg.ExecuteRegionLength[idx]);
  assign rule_hit[0] = (k_q < N_CA_K) &&
      range_hit(addr_q, CVA6Cfg.CachedRegionAddrBase[idx], CVA6Cfg.CachedRegionLength[idx]);

  // A kill in the handshake cycle still lets the response count as delivered,
  // but it must not refresh the memo, which kill invalidates.
  assign resp_done = (state_q == RESP) && resp_ready_i && !kill_i;

`ifdef CVA6_PMA_LASTHIT_EN
  logic        memo_valid_q;
  logic [63:0] memo_addr_q;
  logic [2:0]  memo_flags_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          memo_valid_q <= 1'b0;
    else if (kill_i)    memo_valid_q <= 1'b0;
    else if (resp_done) memo_valid_q <= 1'b1;
  end

  // NOTE: the memo payload has no reset; memo_valid_q alone gates its use.
  always_ff @(posedge clk_i) begin
    if (resp_done) begin
      memo_addr_q  <= addr_q;
      memo_flags_q <= flags_q;
    end
  end

  assign memo_hit   = memo_valid_q && (req_addr_i == memo_addr_q);
  assign memo_flags = memo_flags_q;
`else
  assign memo_hit   = 1'b0;
  assign memo_flags = 3'b000;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      // Kill wins over everything, including a request offered in IDLE.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (req_valid_i) state_d = (SKIP_SCAN || memo_hit) ? RESP : SCAN;
        SCAN:    if (k_q == LAST_K) state_d = RESP;
        RESP:    if (resp_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o  = (state_q == IDLE);
    resp_valid_o = (state_q == RESP);
    {resp_nonidem_o, resp_exec_o, resp_cached_o} = (state_q == RESP) ? flags_q : 3'b000;
  end

  // NOTE: registers update with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      k_q     <= '0;
      flags_q <= '0;
    end else if (kill_i) begin
      k_q     <= '0;
      flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            k_q     <= '0;
            flags_q <= memo_hit ? memo_flags : 3'b000;
          end
        end
        SCAN: begin
          flags_q <= flags_q | rule_hit;
          k_q     <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pma_region_scanner.sv
// Self-checking bench for pma_region_scanner using the three-table setup
// NonIdem = {0x0/0x8000_0000}, Exec = {0x0/0x1000, 0x8000_0000/0x4000_0000},
// Cached = {0x8000_0000/0x4000_0000}, which gives N = 2. Expected flags and
// latency are pushed to a scoreboard when a request is driven; a negedge
// monitor compares them when the DUT presents a response.

module tb_pma_region_scanner;

  function automatic config_pkg::cva6_cfg_t make_cfg();
    config_pkg::cva6_cfg_t c;
    c = config_pkg::cva6_cfg_empty;
    c.NrNonIdempotentRules     = 1;
    c.NonIdempotentAddrBase[0] = 64'h0;
    c.NonIdempotentLength[0]   = 64'h8000_0000;
    c.NrExecuteRegionRules     = 2;
    c.ExecuteRegionAddrBase[0] = 64'h0;
    c.ExecuteRegionLength[0]   = 64'h1000;
    c.ExecuteRegionAddrBase[1] = 64'h8000_0000;
    c.ExecuteRegionLength[1]   = 64'h4000_0000;
    c.NrCachedRegionRules      = 1;
    c.CachedRegionAddrBase[0]  = 64'h8000_0000;
    c.CachedRegionLength[0]    = 64'h4000_0000;
    return c;
  endfunction

  localparam config_pkg::cva6_cfg_t TB_CFG = make_cfg();
  localparam int SCAN_LAT = 3;  // N + 1 with N = 2

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic        kill_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic        resp_nonidem_o;
  logic        resp_exec_o;
  logic        resp_cached_o;

  pma_region_scanner #(.CVA6Cfg(TB_CFG)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .kill_i         (kill_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_nonidem_o (resp_nonidem_o),
    .resp_exec_o    (resp_exec_o),
    .resp_cached_o  (resp_cached_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  flags;  // {nonidem, exec, cached}
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          seen_valid = 1'b0;
  int          first_cyc = 0;
  int          last_acc = 0;
  bit          memo_v = 1'b0;
  logic [63:0] memo_a = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a request and return one cycle after the accepting edge. When
  // push is set, the expected response is queued for the monitor.
  task automatic send(input logic [63:0] addr, input logic [2:0] flags,
                      input bit push, output int lat);
    int   budget;
    exp_t e;
    budget = 50;
    lat    = SCAN_LAT;
`ifdef CVA6_PMA_LASTHIT_EN
    if (memo_v && memo_a == addr) lat = 1;
`endif
    req_addr_i  = addr;
    req_valid_i = 1'b1;
    if (push) begin
      e.addr  = addr;
      e.flags = flags;
      e.lat   = lat;
      exp_q.push_back(e);
      memo_v = 1'b1;
      memo_a = addr;
    end
    while (!req_ready_o && budget > 0) begin
      tick();
      budget--;
    end
    if (!req_ready_o) check("accept_timeout", {63'b0, req_ready_o}, 64'd1);
    tick();
    last_acc    = cyc;
    req_valid_i = 1'b0;
    req_addr_i  = ~addr;  // later changes must not affect the scan
  endtask

  task automatic wait_done();
    int budget;
    budget = 100;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("resp_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Response monitor: compares every cycle a response is presented (so
  // back-pressure stability is covered) and pops on the handshake.
  always @(negedge clk) begin
    if (rst_i) begin
      acc_q.delete();
      seen_valid = 1'b0;
    end else begin
      if (resp_valid_o) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          first_cyc  = cyc;
        end
        if (exp_q.size() == 0) begin
          check("resp_unexpected", {63'b0, resp_valid_o}, 64'd0);
        end else begin
          check($sformatf("nonidem@%0h", exp_q[0].addr), {63'b0, resp_nonidem_o}, {63'b0, exp_q[0].flags[2]});
          check($sformatf("exec@%0h", exp_q[0].addr),    {63'b0, resp_exec_o},    {63'b0, exp_q[0].flags[1]});
          check($sformatf("cached@%0h", exp_q[0].addr),  {63'b0, resp_cached_o},  {63'b0, exp_q[0].flags[0]});
          check("ready_in_resp", {63'b0, req_ready_o}, 64'd0);
          if (resp_ready_i) begin
            if (acc_q.size() == 0) begin
              check("accept_missing", 64'(acc_q.size()), 64'd1);
            end else begin
              check($sformatf("latency@%0h", exp_q[0].addr),
                    64'(first_cyc - acc_q[0] + 1), 64'(exp_q[0].lat));
              void'(acc_q.pop_front());
            end
            void'(exp_q.pop_front());
            seen_valid = 1'b0;
          end
        end
      end
      if (req_valid_i && req_ready_o && !kill_i) acc_q.push_back(cyc + 1);
      if (kill_i) begin
        acc_q.delete();
        seen_valid = 1'b0;
      end
    end
  end

  logic [63:0] tbl_a[10] = '{64'h8000_1000, 64'h0000_0800, 64'hBFFF_FFFF, 64'hC000_0000,
                             64'h0000_1000, 64'h7FFF_FFFF, 64'h8000_0000,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0FFF, 64'h4000_0000};
  logic [2:0]  tbl_f[10] = '{3'b011, 3'b110, 3'b011, 3'b000, 3'b100, 3'b100, 3'b011,
                             3'b000, 3'b110, 3'b100};

  initial begin
    int lat;
    int prev_lat;
    int prev_acc;
    int budget;

    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    kill_i       = 1'b0;
    resp_ready_i = 1'b1;
    repeat (2) tick();
    check("rst_req_ready",  {63'b0, req_ready_o},  64'd1);
    check("rst_resp_valid", {63'b0, resp_valid_o}, 64'd0);
    check("rst_flags", {61'b0, resp_nonidem_o, resp_exec_o, resp_cached_o}, 64'd0);
    rst_i = 1'b0;
    tick();

    // Classification table, one request at a time.
    for (int i = 0; i < 10; i++) begin
      send(tbl_a[i], tbl_f[i], 1'b1, lat);
      wait_done();
    end

    // Back-to-back requests with resp_ready high: one accept per N+2 cycles.
    prev_lat = 0;
    prev_acc = 0;
    for (int i = 1; i < 5; i++) begin
      send(tbl_a[i], tbl_f[i], 1'b1, lat);
      if (i > 1) check("throughput_gap", 64'(last_acc - prev_acc), 64'(prev_lat + 1));
      prev_acc = last_acc;
      prev_lat = lat;
    end
    wait_done();

    // Kill one cycle into SCAN: no response, ready again next cycle.
    send(64'h8000_0000, 3'b011, 1'b0, lat);
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    memo_v = 1'b0;
    check("kill_req_ready",  {63'b0, req_ready_o},  64'd1);
    check("kill_resp_valid", {63'b0, resp_valid_o}, 64'd0);
    repeat (4) tick();
    send(64'h0000_0010, 3'b110, 1'b1, lat);
    wait_done();

    // Back-pressure: RESP holds for 5 cycles, handshake on the 6th.
    resp_ready_i = 1'b0;
    send(64'h0000_0800, 3'b110, 1'b1, lat);
    budget = 20;
    while (!resp_valid_o && budget > 0) begin
      tick();
      budget--;
    end
    check("bp_resp_seen", {63'b0, resp_valid_o}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_req_ready",  {63'b0, req_ready_o},  64'd0);
      check("bp_resp_valid", {63'b0, resp_valid_o}, 64'd1);
      tick();
    end
    resp_ready_i = 1'b1;
    tick();
    check("bp_done_valid", {63'b0, resp_valid_o}, 64'd0);
    check("bp_done_ready", {63'b0, req_ready_o},  64'd1);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Repeat address: memo hit when enabled, full scan otherwise; kill clears it.
    send(64'h8000_1000, 3'b011, 1'b1, lat);
    wait_done();
    send(64'h8000_1000, 3'b011, 1'b1, lat);
    wait_done();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    memo_v = 1'b0;
    send(64'h8000_1000, 3'b011, 1'b1, lat);
    wait_done();

    // Asynchronous reset mid-SCAN: outputs return to reset values before any edge.
    send(64'h8000_1000, 3'b011, 1'b0, lat);
    #2 rst_i = 1'b1;
    #1;
    check("arst_req_ready",  {63'b0, req_ready_o},  64'd1);
    check("arst_resp_valid", {63'b0, resp_valid_o}, 64'd0);
    check("arst_flags", {61'b0, resp_nonidem_o, resp_exec_o, resp_cached_o}, 64'd0);
    tick();
    rst_i  = 1'b0;
    memo_v = 1'b0;
    repeat (3) tick();
    send(64'hC000_0000, 3'b000, 1'b1, lat);
    wait_done();
    send(64'h0000_0FFF, 3'b110, 1'b1, lat);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", n_checks, n_errors);
    $fatal(1);
  end

endmodule
